// File: rtl/score_pkg.sv
// Shared types and constants for the multi-user score table.
package score_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_UPD,
    ST_SCAN,
    ST_CONV,
    ST_SHOW
  } state_e;

  typedef enum logic [1:0] {
    OP_WIN,
    OP_LOOSE,
    OP_DISP
  } op_e;

  function automatic int score_max(input int score_w);
    return (1 << score_w) - 1;
  endfunction

  // Smallest number of BCD digits whose range covers every score value.
  function automatic int min_digits(input int score_w);
    longint lim;
    longint pow;
    int     d;
    lim = (longint'(1) << score_w) - 1;
    pow = 10;
    d   = 1;
    for (int i = 0; i < 20; i++) begin
      if (pow <= lim) begin
        pow = pow * 10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

  localparam int SCORE_W_DEF = 6;
  localparam int SCORE_MAX   = (1 << SCORE_W_DEF) - 1;

endpackage

// File: rtl/score_bcd_conv.sv
// Sequential double-dabble: one shift-add-3 step per cycle, SCORE_W steps.
// bcd_out carries the finished result in the cycle done is high.
module score_bcd_conv #(
  parameter int SCORE_W = 6,
  parameter int DIGITS  = 2
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SCORE_W-1:0]    bin_in,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   bcd_step;

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end
    bcd_step = {adj[BCD_W-2:0], bin_q[SCORE_W-1]};
  end

  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done    = 1'b0;
    bcd_out = bcd_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (run_q) begin
      bin_d = {bin_q[SCORE_W-2:0], 1'b0};
      bcd_d = bcd_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d   = 1'b0;
        done    = 1'b1;
        bcd_out = bcd_step;
      end
    end else if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      cnt_d = CNT_W'(SCORE_W);
      run_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/score_table_mu.sv
// Multi-user score table: per-user scores, top-score tracking with rescan, BCD readout.
//   state | meaning
//   IDLE  | waiting for an accepted request
//   RD    | read the latched user's slot
//   UPD   | write the updated score, update or invalidate the top score
//   SCAN  | walk all slots to rebuild the top score after the holder lost
//   CONV  | binary-to-BCD conversion of the slot value
//   SHOW  | display register loaded, disp_valid set
module score_table_mu
  import score_pkg::*;
#(
  parameter int NUM_USERS    = 8,
  parameter int ID_W         = $clog2(NUM_USERS),
  parameter int SCORE_W      = $clog2(SCORE_MAX + 1),
  parameter int LEVEL_W      = 4,
  parameter int LOSS_PENALTY = 1,
  parameter int DIGITS       = 2
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  auth_bit,
  input  logic                  green_user,
  input  logic                  log_out,
  input  logic [ID_W-1:0]       internal_id,
  input  logic [LEVEL_W-1:0]    level_num,
  input  logic                  win,
  input  logic                  loose,
  input  logic                  disp_button,
  output logic [4*DIGITS-1:0]   disp_out,
  output logic                  disp_valid,
  output logic                  green_max,
  output logic [SCORE_W-1:0]    max_score,
  output logic [ID_W-1:0]       max_id,
  output logic                  busy
);

  localparam int                SUM_W   = (SCORE_W > LEVEL_W ? SCORE_W : LEVEL_W) + 1;
  localparam logic [SUM_W-1:0]  SAT     = SUM_W'(score_max(SCORE_W));
  localparam logic [SCORE_W-1:0] PEN    = SCORE_W'(LOSS_PENALTY);
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_USERS - 1);

  if (DIGITS < min_digits(SCORE_W)) begin : g_digits_check
    $error("DIGITS too small for SCORE_W");
  end

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [SCORE_W-1:0]    score_q [NUM_USERS];
  logic [SCORE_W-1:0]    score_d [NUM_USERS];
  logic [ID_W-1:0]       id_q, id_d;
  logic [LEVEL_W-1:0]    lvl_q, lvl_d;
  logic [SCORE_W-1:0]    rd_q, rd_d;
  logic [ID_W-1:0]       scan_idx_q, scan_idx_d;
  logic [SCORE_W-1:0]    best_q, best_d;
  logic [ID_W-1:0]       best_id_q, best_id_d;
  logic [SCORE_W-1:0]    max_score_q, max_score_d;
  logic [ID_W-1:0]       max_id_q, max_id_d;
  logic [4*DIGITS-1:0]   disp_out_q, disp_out_d;
  logic                  disp_valid_q, disp_valid_d;
  logic                  green_max_q, green_max_d;

  logic                  req_ok, win_acc, loose_acc, disp_acc;
  logic [ID_W-1:0]       rd_addr;
  logic [SCORE_W-1:0]    rd_data;
  logic [SUM_W-1:0]      sum;
  logic [SCORE_W-1:0]    win_val, loose_val, new_val;
  logic                  take;
  logic                  conv_start, conv_abort, conv_done;
  logic [4*DIGITS-1:0]   conv_bcd;

  score_bcd_conv #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clock   (clock),
    .rst     (rst),
    .start   (conv_start),
    .abort   (conv_abort),
    .bin_in  (rd_data),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    score_d      = score_q;
    id_d         = id_q;
    lvl_d        = lvl_q;
    rd_d         = rd_q;
    scan_idx_d   = scan_idx_q;
    best_d       = best_q;
    best_id_d    = best_id_q;
    max_score_d  = max_score_q;
    max_id_d     = max_id_q;
    disp_out_d   = disp_out_q;
    disp_valid_d = disp_valid_q;
    conv_start   = 1'b0;
    conv_abort   = 1'b0;

    req_ok    = auth_bit && green_user && !log_out && (state_q == ST_IDLE);
    win_acc   = req_ok && win && !loose;
    loose_acc = req_ok && loose && !win;
    disp_acc  = req_ok && disp_button && !win && !loose;

    rd_addr = (state_q == ST_SCAN) ? scan_idx_q : id_q;
    rd_data = score_q[rd_addr];

    sum       = SUM_W'(rd_q) + SUM_W'(lvl_q);
    win_val   = (sum > SAT) ? SAT[SCORE_W-1:0] : sum[SCORE_W-1:0];
    loose_val = (rd_q < PEN) ? '0 : rd_q - PEN;
    new_val   = (op_q == OP_WIN) ? win_val : loose_val;
    // Strict compare keeps the lowest index on ties during the walk.
    take      = (scan_idx_q == '0) || (rd_data > best_q);

    case (state_q)
      ST_IDLE: begin
        if (win_acc || loose_acc || disp_acc) begin
          id_d    = internal_id;
          lvl_d   = level_num;
          op_d    = win_acc ? OP_WIN : (loose_acc ? OP_LOOSE : OP_DISP);
          state_d = ST_RD;
        end
        if (win_acc || loose_acc) disp_valid_d = 1'b0;
      end
      ST_RD: begin
        rd_d = rd_data;
        if (op_q == OP_DISP) begin
          conv_start = 1'b1;
          state_d    = ST_CONV;
        end else begin
          state_d = ST_UPD;
        end
      end
      ST_UPD: begin
        score_d[id_q] = new_val;
        state_d       = ST_IDLE;
        if (op_q == OP_WIN) begin
          if (new_val > max_score_q) begin
            max_score_d = new_val;
            max_id_d    = id_q;
          end
        end else if (id_q == max_id_q) begin
          scan_idx_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (take) begin
          best_d    = rd_data;
          best_id_d = scan_idx_q;
        end
        if (scan_idx_q == LAST_ID) begin
          max_score_d = take ? rd_data : best_q;
          max_id_d    = take ? scan_idx_q : best_id_q;
          state_d     = ST_IDLE;
        end else begin
          scan_idx_d = scan_idx_q + ID_W'(1);
        end
      end
      ST_CONV: begin
        if (log_out) begin
          conv_abort = 1'b1;
          state_d    = ST_IDLE;
        end else if (conv_done) begin
          disp_out_d   = conv_bcd;
          disp_valid_d = 1'b1;
          state_d      = ST_SHOW;
        end
      end
      ST_SHOW: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (log_out) disp_valid_d = 1'b0;

    green_max_d = auth_bit && (internal_id == max_id_q) && (max_score_q != '0);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_WIN;
      score_q      <= '{default: '0};
      id_q         <= '0;
      lvl_q        <= '0;
      rd_q         <= '0;
      scan_idx_q   <= '0;
      best_q       <= '0;
      best_id_q    <= '0;
      max_score_q  <= '0;
      max_id_q     <= '0;
      disp_out_q   <= '0;
      disp_valid_q <= 1'b0;
      green_max_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      score_q      <= score_d;
      id_q         <= id_d;
      lvl_q        <= lvl_d;
      rd_q         <= rd_d;
      scan_idx_q   <= scan_idx_d;
      best_q       <= best_d;
      best_id_q    <= best_id_d;
      max_score_q  <= max_score_d;
      max_id_q     <= max_id_d;
      disp_out_q   <= disp_out_d;
      disp_valid_q <= disp_valid_d;
      green_max_q  <= green_max_d;
    end
  end

  assign disp_out   = disp_out_q;
  assign disp_valid = disp_valid_q;
  assign green_max  = green_max_q;
  assign max_score  = max_score_q;
  assign max_id     = max_id_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_score_table_mu.sv
// Scoreboard bench for score_table_mu: each accepted request queues its expected
// completion; a monitor checks it when busy drops.
module tb_score_table_mu;

  localparam int NU = 8;
  localparam int IW = 3;
  localparam int SW = 6;
  localparam int LW = 4;
  localparam int DG = 2;

  logic          clock = 1'b0;
  logic          rst;
  logic          auth_bit, green_user, log_out;
  logic [IW-1:0] internal_id;
  logic [LW-1:0] level_num;
  logic          win, loose, disp_button;
  logic [4*DG-1:0] disp_out;
  logic          disp_valid, green_max, busy;
  logic [SW-1:0] max_score;
  logic [IW-1:0] max_id;

  score_table_mu #(
    .NUM_USERS    (NU),
    .ID_W         (IW),
    .SCORE_W      (SW),
    .LEVEL_W      (LW),
    .LOSS_PENALTY (1),
    .DIGITS       (DG)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .auth_bit    (auth_bit),
    .green_user  (green_user),
    .log_out     (log_out),
    .internal_id (internal_id),
    .level_num   (level_num),
    .win         (win),
    .loose       (loose),
    .disp_button (disp_button),
    .disp_out    (disp_out),
    .disp_valid  (disp_valid),
    .green_max   (green_max),
    .max_score   (max_score),
    .max_id      (max_id),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int mx;
    int id;
    int len;
    int dv;
    int cd;
    int dout;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   blen   = 0;
  logic bprev  = 1'b0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  // Monitor: a completed request is a falling edge of busy.
  initial begin
    forever begin
      @(negedge clock);
      if (rst) begin
        bprev = 1'b0;
        blen  = 0;
      end else begin
        if (busy) begin
          blen++;
        end else if (bprev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got busy run of %0d cycles, expected none", blen);
          end else begin
            cur = exp_q.pop_front();
            chk("txn_max_score", int'(max_score), cur.mx);
            chk("txn_max_id", int'(max_id), cur.id);
            chk("txn_busy_len", blen, cur.len);
            chk("txn_disp_valid", int'(disp_valid), cur.dv);
            if (cur.cd != 0) chk("txn_disp_out", int'(disp_out), cur.dout);
          end
          blen = 0;
        end
        bprev = busy;
      end
    end
  end

  task automatic push_exp(input int mx, input int id, input int len,
                          input int dv, input int cd, input int dout);
    exp_t e;
    e.mx = mx; e.id = id; e.len = len; e.dv = dv; e.cd = cd; e.dout = dout;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic w, input logic l, input logic d,
                       input int id, input int lvl);
    @(posedge clock);
    #1;
    internal_id = IW'(id);
    level_num   = LW'(lvl);
    win = w; loose = l; disp_button = d;
    @(posedge clock);
    #1;
    win = 1'b0; loose = 1'b0; disp_button = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending completions, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Score event: mx/id are the expected top score after completion.
  task automatic do_evt(input logic w, input int id, input int lvl,
                        input int mx, input int mid, input int len);
    push_exp(mx, mid, len, 0, 0, 0);
    drive(w, !w, 1'b0, id, lvl);
    wait_drain();
  endtask

  task automatic do_disp(input int id, input int mx, input int mid, input int dout);
    push_exp(mx, mid, SW + 2, 1, 1, dout);
    drive(1'b0, 1'b0, 1'b1, id, 0);
    wait_drain();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 rst = 1'b1;
    #7 rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    auth_bit = 1'b1; green_user = 1'b1; log_out = 1'b0;
    internal_id = '0; level_num = '0;
    win = 1'b0; loose = 1'b0; disp_button = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;

    chk("rst_max_score", int'(max_score), 0);
    chk("rst_max_id", int'(max_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_disp_valid", int'(disp_valid), 0);
    chk("rst_disp_out", int'(disp_out), 0);
    chk("rst_green_max", int'(green_max), 0);

    // User 3 wins at level 5, then reads back.
    do_evt(1'b1, 3, 5, 5, 3, 2);
    #1;
    chk("green_max_owner", int'(green_max), 1);
    internal_id = 3'd2;
    @(posedge clock); #1;
    chk("green_max_other", int'(green_max), 0);
    internal_id = 3'd3;
    auth_bit = 1'b0;
    @(posedge clock); #1;
    chk("green_max_noauth", int'(green_max), 0);
    auth_bit = 1'b1;
    @(posedge clock); #1;
    chk("green_max_back", int'(green_max), 1);
    do_disp(3, 5, 3, 8'h05);

    // Saturation: 5 + 5*15 clamps at 63; the tie at 63 keeps the owner.
    do_evt(1'b1, 3, 15, 20, 3, 2);
    do_evt(1'b1, 3, 15, 35, 3, 2);
    do_evt(1'b1, 3, 15, 50, 3, 2);
    do_evt(1'b1, 3, 15, 63, 3, 2);
    do_evt(1'b1, 3, 15, 63, 3, 2);
    do_disp(3, 63, 3, 8'h63);

    // Top-score rescan.
    do_reset();
    do_evt(1'b1, 1, 10, 10, 1, 2);
    do_evt(1'b1, 4, 10, 10, 1, 2);
    do_evt(1'b1, 6, 12, 12, 6, 2);
    do_evt(1'b0, 6, 0, 11, 6, 2 + NU);
    do_evt(1'b0, 6, 0, 10, 1, 2 + NU);
    do_evt(1'b0, 6, 0, 10, 1, 2);
    do_evt(1'b0, 4, 0, 10, 1, 2);
    do_evt(1'b0, 0, 0, 10, 1, 2);
    do_disp(0, 10, 1, 8'h00);

    // Dropped requests: win+loose together, no auth, no green_user.
    drive(1'b1, 1'b1, 1'b0, 1, 5);
    chk("drop_win_loose_busy", int'(busy), 0);
    auth_bit = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2, 5);
    chk("drop_noauth_busy", int'(busy), 0);
    auth_bit = 1'b1;
    green_user = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2, 5);
    chk("drop_nogreen_busy", int'(busy), 0);
    green_user = 1'b1;

    // Win during a rescan is dropped; user 2 stays at 0.
    push_exp(9, 1, 2 + NU, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1, 0);
    drive(1'b1, 1'b0, 1'b0, 2, 7);
    wait_drain();
    do_disp(2, 9, 1, 8'h00);

    // log_out mid-conversion aborts; disp_out keeps its old value.
    push_exp(9, 1, 3, 0, 1, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 6, 0);
    @(posedge clock);
    @(posedge clock);
    #1 log_out = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_disp_valid", int'(disp_valid), 0);
    log_out = 1'b0;
    wait_drain();
    do_disp(6, 9, 1, 8'h09);

    // Asynchronous reset while a win is in UPD.
    drive(1'b1, 1'b0, 1'b0, 5, 9);
    internal_id = 3'd1;
    @(posedge clock);
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_green_max", int'(green_max), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_max_score", int'(max_score), 0);
    chk("async_rst_max_id", int'(max_id), 0);
    chk("async_rst_green_max", int'(green_max), 0);
    chk("async_rst_disp_out", int'(disp_out), 0);
    chk("async_rst_disp_valid", int'(disp_valid), 0);
    #3 rst = 1'b0;
    exp_q.delete();
    do_disp(5, 0, 0, 8'h00);

    repeat (3) @(posedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_table_mu.md
Name: score_table_mu

Overview:
- Parametrised multi-user score table for the memory-tester game. Successor to the fixed 8-user, 6-bit score table.
- Holds one score per user and updates it on win/loose events, weighted by the current level.
- Tracks the all-time top score and its owner, including a rescan when the top holder loses.
- Produces a sequential BCD readout of the logged-in user's score for the display path.

Parameters:
- NUM_USERS, 8, number of user slots (≥2).
- ID_W, $clog2(NUM_USERS), width of internal_id.
- SCORE_W, 6, score width in bits.
- LEVEL_W, 4, width of level_num.
- LOSS_PENALTY, 1, amount subtracted on loose.
- DIGITS, 2, BCD digits on disp_out. Must satisfy 10^DIGITS > 2^SCORE_W-1.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- auth_bit  in  1  user authenticated.
- green_user  in  1  user entry valid; qualifies all requests.
- log_out  in  1  session end; clears display state.
- internal_id  in  ID_W  current user slot.
- level_num  in  LEVEL_W  current level, used as win increment.
- win  in  1  one-cycle pulse: round won.
- loose  in  1  one-cycle pulse: round lost.
- disp_button  in  1  one-cycle pulse: request score readout.
- disp_out  out  4*DIGITS  BCD score, digit 0 in LSBs.
- disp_valid  out  1  disp_out holds a finished conversion.
- green_max  out  1  current user holds the top score.
- max_score  out  SCORE_W  top score.
- max_id  out  ID_W  owner of the top score.
- busy  out  1  FSM not in IDLE; new requests are dropped.

Behaviour:
- Reset (async, any state):
  - all score slots=0; max_score=0, max_id=0.
  - disp_out=0, disp_valid=0, green_max=0, busy=0, FSM=IDLE.
  - Any in-flight write is abandoned.
- Request acceptance:
  - Accept a request only when auth_bit && green_user && !log_out && state==IDLE.
  - Otherwise the request is dropped silently, with no queuing.
  - win && loose in the same cycle: both ignored.
  - win/loose together with disp_button: the score event wins; disp_button is dropped.
  - internal_id and level_num are latched at acceptance.
- FSM states: IDLE, RD, UPD, SCAN, CONV, SHOW.
- Score update path (IDLE -> RD -> UPD):
  - Acceptance at cycle 0; RD at cycle 1 reads the slot; UPD at cycle 2 writes the slot.
  - The new score is visible from cycle 3. busy=1 in cycles 1-2.
  - win: new = min(old + level_num, 2^SCORE_W-1), saturating. level_num=0 still writes.
  - loose: new = max(old - LOSS_PENALTY, 0), floored.
  - Any accepted event clears disp_valid.
- Top-score tracking:
  - win with new > max_score (strict): max_score/max_id update in the UPD cycle. A tie keeps the old owner.
  - loose where slot != max_id: max unchanged.
  - loose where slot == max_id: UPD -> SCAN.
    - SCAN walks slots 0..NUM_USERS-1, one per cycle.
    - Result: highest value, lowest index on ties.
    - max_score/max_id are written on the last SCAN cycle, then IDLE.
    - Total busy for this path = 2 + NUM_USERS cycles.
- Display path (IDLE -> RD -> CONV -> SHOW -> IDLE):
  - Entered on accepted disp_button; RD reads the current slot.
  - CONV runs a sequential double-dabble of exactly SCORE_W cycles.
  - SHOW, one cycle: disp_out loaded, disp_valid=1.
  - disp_valid stays high until the next accepted win/loose, log_out, or reset.
  - log_out during CONV aborts to IDLE with disp_out unchanged and disp_valid=0.
- green_max: registered each cycle as auth_bit && (internal_id==max_id) && (max_score!=0).
- log_out never alters stored scores.

Decomposition:
- Shared package score_pkg:
  - FSM state enum.
  - Helper function computing the minimum DIGITS from SCORE_W.
  - Saturation constant SCORE_MAX = 2^SCORE_W-1.
- Sub-module score_bcd_conv:
  - Sequential double-dabble.
  - Interface: start/done handshake, bin_in[SCORE_W], bcd_out[4*DIGITS].
  - done is a one-cycle pulse after SCORE_W cycles.
  - Reset and abort return it to idle.
- Score storage is a register array inside score_table_mu, with single read and write per cycle.

Test Plan:
- Reset, then user 3 win at level 5, then disp_button → score[3]=5, max_score=5, max_id=3, green_max=1 with id 3; disp_out=8'h05, disp_valid=1 after SCORE_W+2 cycles.
- User 3 wins with level_num=15 five times (5+75) → saturates at 63; disp_out=8'h63.
- Users 1=10, 4=10, 6=12, with 6 as max; user 6 loose → SCAN gives max_score=11, max_id=6. Then user 6 loose twice more (to 9) → max_score=10, max_id=1 (lowest index on tie); busy exactly 2+NUM_USERS cycles per rescan.
- win and loose pulsed in the same cycle, and win pulsed while busy → no score change, FSM stays idle or on the current path.
- log_out asserted mid-CONV → disp_valid=0, FSM=IDLE within 1 cycle; the next disp_button works normally.
- Async rst asserted during UPD of a win → slot unchanged (0), all outputs at reset values immediately, without waiting for a clock edge.
